// File: rtl/data_mem_responder.sv
// 16-bit word memory with a fixed-latency read return path and odd-address request rejection.
// Read data returns exactly LATENCY cycles after the request; no backpressure, one request per cycle.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_BITS  = 13,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           data_in,
  output logic [15:0]           data_out,
  output logic                  data_valid,
  output logic [3:0]            outstanding,
  output logic                  misalign
);

  localparam int DEPTH = 1 << WORD_BITS;

  logic [15:0]          mem [DEPTH];
  logic [WORD_BITS-1:0] word_idx;
  logic                 req_ok;
  logic                 rd_acc;
  logic                 wr_acc;
  logic [LATENCY-1:0]   pipe_vld;
  logic [15:0]          pipe_dat [LATENCY];

  assign word_idx = addr[WORD_BITS:1];

  // Requests seen while reset is held are never accepted, even though the array itself is not reset.
  assign req_ok = enable & ~addr[0] & rst_n;
  assign rd_acc = req_ok & ~wr;
  assign wr_acc = req_ok & wr;

  generate
    if (ADDR_WIDTH > WORD_BITS + 1) begin : g_alias
      logic unused_hi_addr;
      assign unused_hi_addr = ^addr[ADDR_WIDTH-1:WORD_BITS+1];
    end
  endgenerate

  // Array and data pipeline carry no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[word_idx] <= data_in;
    end
    if (rd_acc) begin
      pipe_dat[0] <= mem[word_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_dat[i] <= pipe_dat[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld    <= '0;
      outstanding <= '0;
      misalign    <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
      outstanding <= outstanding + 4'(rd_acc) - 4'(data_valid);
      misalign    <= enable & addr[0];
    end
  end

  assign data_valid = pipe_vld[LATENCY-1];
  assign data_out   = data_valid ? pipe_dat[LATENCY-1] : 16'h0000;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic against a cycle-indexed model,
// run on a LATENCY=4 and a LATENCY=1 instance sharing the same request stream.
module tb_data_mem_responder;

  localparam int MAXC = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] data_in = 16'h0;

  logic [15:0] d4_out, d1_out;
  logic        d4_vld, d1_vld;
  logic [3:0]  d4_os, d1_os;
  logic        d4_mis, d1_mis;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 1'b0;

  // Model: word array plus per-cycle record of accepted reads and dropped requests.
  logic [15:0] mem_m [8192];
  bit          rd_at [MAXC];
  logic [15:0] rd_dat [MAXC];
  bit          mis_at [MAXC];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(16), .WORD_BITS(13), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(d4_out), .data_valid(d4_vld), .outstanding(d4_os), .misalign(d4_mis)
  );

  data_mem_responder #(.ADDR_WIDTH(16), .WORD_BITS(13), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(d1_out), .data_valid(d1_vld), .outstanding(d1_os), .misalign(d1_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit ev(input int lat);
    return (cyc >= lat) && rd_at[cyc-lat];
  endfunction

  function automatic logic [15:0] ed(input int lat);
    return ev(lat) ? rd_dat[cyc-lat] : 16'h0000;
  endfunction

  function automatic int eo(input int lat);
    int s = 0;
    for (int k = 1; k <= lat; k++) begin
      if (cyc - k >= 0 && rd_at[cyc-k]) s++;
    end
    return s;
  endfunction

  function automatic bit em();
    return (cyc >= 1) && mis_at[cyc-1];
  endfunction

  // Every cycle: both instances against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("vld4", 32'(d4_vld), 32'(ev(4)));
      chk("dout4", 32'(d4_out), 32'(ed(4)));
      chk("os4", 32'(d4_os), eo(4));
      chk("mis4", 32'(d4_mis), 32'(em()));
      chk("vld1", 32'(d1_vld), 32'(ev(1)));
      chk("dout1", 32'(d1_out), 32'(ed(1)));
      chk("os1", 32'(d1_os), eo(1));
      chk("mis1", 32'(d1_mis), 32'(em()));
    end
  end

  task automatic step(input bit en, input bit w, input logic [15:0] a, input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    if (cyc < MAXC - 1) begin
      rd_at[cyc]  = rst_n && en && !a[0] && !w;
      if (rd_at[cyc]) rd_dat[cyc] = mem_m[a[13:1]];
      mis_at[cyc] = rst_n && en && a[0];
      if (rst_n && en && !a[0] && w) mem_m[a[13:1]] = d;
      cyc++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (cyc - k >= 0) begin
        rd_at[cyc-k]  = 1'b0;
        mis_at[cyc-k] = 1'b0;
      end
    end
    #1;
    chk("rst_os4", 32'(d4_os), 32'd0);
    chk("rst_vld4", 32'(d4_vld), 32'd0);
    chk("rst_dout4", 32'(d4_out), 32'd0);
    chk("rst_mis4", 32'(d4_mis), 32'd0);
    repeat (n) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    rst_n = 1'b1;
  endtask

  logic [15:0] lit3 [3];
  int          pulses;
  logic [15:0] ra;

  initial begin
    lit3[0] = 16'h1111;
    lit3[1] = 16'h2222;
    lit3[2] = 16'h3333;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    run = 1'b1;
    // Requests during reset are ignored.
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    step(1'b1, 1'b1, 16'h0010, 16'h1234);
    chk("reset_vld", 32'(d4_vld), 32'd0);
    chk("reset_os", 32'(d4_os), 32'd0);
    chk("reset_dout", 32'(d4_out), 32'd0);
    chk("reset_mis", 32'(d1_mis), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8192; i++) begin
      step(1'b1, 1'b1, 16'(i * 2), 16'(i) ^ 16'hA5C3);
    end

    // Write then read the same word: 4-cycle return, outstanding 1 for 4 cycles.
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    chk("s31_os_a", 32'(d4_os), 32'd1);
    chk("s31_l1_dout", 32'(d1_out), 32'h0000BEEF);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("s31_os_b", 32'(d4_os), 32'd1);
    end
    chk("s31_vld", 32'(d4_vld), 32'd1);
    chk("s31_dout", 32'(d4_out), 32'h0000BEEF);
    idle(1);
    chk("s31_os_end", 32'(d4_os), 32'd0);
    chk("s31_vld_end", 32'(d4_vld), 32'd0);

    // Three writes, three back-to-back reads.
    step(1'b1, 1'b1, 16'h0000, 16'h1111);
    step(1'b1, 1'b1, 16'h0002, 16'h2222);
    step(1'b1, 1'b1, 16'h0004, 16'h3333);
    step(1'b1, 1'b0, 16'h0000, 16'h0);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    step(1'b1, 1'b0, 16'h0004, 16'h0);
    chk("s32_os_peak", 32'(d4_os), 32'd3);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("s32_vld", 32'(d4_vld), 32'd1);
      chk("s32_dout", 32'(d4_out), 32'(lit3[k]));
    end
    idle(1);
    chk("s32_os_end", 32'(d4_os), 32'd0);

    // Odd addresses are dropped.
    step(1'b1, 1'b0, 16'h0003, 16'h0);
    chk("s33_mis", 32'(d4_mis), 32'd1);
    chk("s33_os", 32'(d4_os), 32'd0);
    step(1'b1, 1'b1, 16'h0003, 16'hDEAD);
    chk("s33_mis2", 32'(d4_mis), 32'd1);
    chk("s33_l1_vld", 32'(d1_vld), 32'd0);
    idle(1);
    chk("s33_mis_clr", 32'(d4_mis), 32'd0);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    idle(3);
    chk("s33_word1", 32'(d4_out), 32'h00002222);

    // Reset mid-flight flushes reads; array survives.
    idle(2);
    step(1'b1, 1'b0, 16'h0000, 16'h0);
    step(1'b1, 1'b0, 16'h0002, 16'h0);
    reset_pulse(1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      if (d4_vld) pulses++;
    end
    chk("s34_no_vld", 32'(pulses), 32'd0);
    chk("s34_os", 32'(d4_os), 32'd0);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    idle(3);
    chk("s34_keep", 32'(d4_out), 32'h0000BEEF);

    // Upper address bits alias.
    step(1'b1, 1'b1, 16'h4010, 16'hCAFE);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    chk("s36_l1", 32'(d1_out), 32'h0000CAFE);
    idle(3);
    chk("s36_l4", 32'(d4_out), 32'h0000CAFE);

    // LATENCY=1 streaming.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 16'((i % 3) * 2), 16'h0);
      chk("s35_vld", 32'(d1_vld), 32'd1);
      chk("s35_os", 32'(d1_os), 32'd1);
      chk("s35_dout", 32'(d1_out), 32'(lit3[i % 3]));
    end
    idle(5);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_pulse(int'($urandom_range(1, 2)));
      end else begin
        ra = 16'($urandom);
        if ($urandom_range(0, 7) != 0) ra[0] = 1'b0;
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, 16'($urandom));
      end
    end
    idle(10);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
